// File: rtl/bcd_accumulator.sv
// bcd_accumulator: debounced button-driven decimal accumulator with a
// sequential double-dabble converter feeding active-low 7-segment digits.
// Optional feature macro: BCD_ACC_SAT_EN (overflowing adds saturate at MAX
// instead of wrapping).
module bcd_accumulator #(
  parameter int SW_W            = 10,
  parameter int DIGITS          = 6,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SW_W-1:0]       sw,
  input  logic                  btn_add_n,
  input  logic                  btn_clr_n,
  input  logic                  btn_preset_n,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  busy,
  output logic                  overflow
);

  localparam int POW10 = 10 ** DIGITS;
  localparam int ACC_W = $clog2(POW10);
  localparam logic [ACC_W-1:0] MAX = ACC_W'(POW10 - 1);
  // Sum is wide enough for either operand plus a carry.
  localparam int SUM_W = ((ACC_W > SW_W) ? ACC_W : SW_W) + 1;
  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + ACC_W;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int BIT_W = $clog2(ACC_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LOAD
  } state_t;

  genvar gi;

  // ---------------------------------------------------------------- buttons
  // Index 0 = add, 1 = clear, 2 = preset.
  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {btn_preset_n, btn_clr_n, btn_add_n};

  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic             sync1_reg;
      logic             sync2_reg;
      logic             level_reg;
      logic             press_reg;
      logic [CNT_W-1:0] cnt_reg;

      // Synchronise, then accept a new level only after it has been stable
      // for DEBOUNCE_CYCLES cycles; pulse once when the accepted level falls.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          level_reg <= 1'b1;
          press_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_reg <= sync2_reg;
            press_reg <= ~sync2_reg;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  // ---------------------------------------------------------- accumulator
  logic [SW_W-1:0]  sw_meta_reg;
  logic [SW_W-1:0]  sw_sync_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_reg;
  logic             ovf_next;
  logic             start_reg;
  logic [SUM_W-1:0] sum;

  // Operand synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      sw_meta_reg <= sw;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  // Next accumulator value; clear beats preset beats add.
  always_comb begin
    acc_next = acc_reg;
    ovf_next = ovf_reg;
    sum      = SUM_W'(acc_reg) + SUM_W'(sw_sync_reg);
    if (press[1]) begin
      acc_next = '0;
      ovf_next = 1'b0;
    end else if (press[2]) begin
      acc_next = MAX;
      ovf_next = 1'b0;
    end else if (press[0]) begin
      if (sum > SUM_W'(MAX)) begin
        ovf_next = 1'b1;
`ifdef BCD_ACC_SAT_EN
        acc_next = MAX;
`else
        acc_next = ACC_W'(sum - SUM_W'(POW10));
`endif
      end else begin
        acc_next = ACC_W'(sum);
      end
    end
  end

  // Accumulator state; start is raised in the first cycle acc holds a new
  // value so the converter snapshot always sees the written result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
      start_reg <= 1'b0;
    end else begin
      acc_reg   <= acc_next;
      ovf_reg   <= ovf_next;
      start_reg <= |press;
    end
  end

  // ------------------------------------------------------------ converter
  state_t           state_reg;
  state_t           state_next;
  logic             pending_reg;
  logic             pending_next;
  logic             snap_en;
  logic             shift_en;
  logic             load_en;
  logic [BIT_W-1:0] bit_cnt_reg;
  logic [SR_W-1:0]  sr_reg;
  logic [BCD_W-1:0] bcd_adj;
  logic [SR_W-1:0]  sr_adj;
  logic [BCD_W-1:0] disp_reg;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dab
      assign bcd_adj[4*gi +: 4] = (sr_reg[ACC_W + 4*gi +: 4] >= 4'd5) ?
                                  sr_reg[ACC_W + 4*gi +: 4] + 4'd3 :
                                  sr_reg[ACC_W + 4*gi +: 4];
    end
  endgenerate

  assign sr_adj = {bcd_adj, sr_reg[ACC_W-1:0]};

  // Next state; writes during a conversion are remembered and coalesced
  // into a single re-run that snapshots acc on leaving LOAD.
  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    snap_en      = 1'b0;
    shift_en     = 1'b0;
    load_en      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_reg) begin
          state_next = ST_SHIFT;
          snap_en    = 1'b1;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (start_reg) pending_next = 1'b1;
        if (bit_cnt_reg == BIT_W'(ACC_W - 1)) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        load_en = 1'b1;
        if (pending_reg || start_reg) begin
          state_next   = ST_SHIFT;
          snap_en      = 1'b1;
          pending_next = 1'b0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      pending_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
    end
  end

  // Converter datapath: snapshot, shift, and display load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_reg      <= '0;
      bit_cnt_reg <= '0;
      disp_reg    <= '0;
    end else begin
      if (load_en) disp_reg <= sr_reg[SR_W-1:ACC_W];
      if (snap_en) begin
        sr_reg      <= {{BCD_W{1'b0}}, acc_reg};
        bit_cnt_reg <= '0;
      end else if (shift_en) begin
        sr_reg      <= sr_adj << 1;
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- output
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_seg
      assign seg[7*gi +: 7] = seg_decode(disp_reg[4*gi +: 4]);
    end
  endgenerate

  assign busy     = (state_reg != ST_IDLE) | pending_reg;
  assign overflow = ovf_reg;

endmodule

// File: doc/bcd_accumulator.md
# bcd_accumulator

Clocked, parametrised successor to the board's switch-accumulator display path. It sums the slide-switch value into a decimal accumulator on each debounced press of the add button; separate buttons clear the accumulator or preset it to its maximum. A sequential double-dabble converter turns the binary total into DIGITS BCD digits, and those digits drive active-low seven-segment outputs. The block sits between the raw board switches/buttons and the HEX displays.

## Interface
- SW_W, 10: switch operand width (1..16).
- DIGITS, 6: decimal digits displayed (1..9). MAX = 10^DIGITS-1. ACC_W = $clog2(10^DIGITS), 20 at default.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles before a button level is accepted (>=2).
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- sw  in  SW_W  unsigned operand, asynchronous, sampled through a 2-FF synchroniser.
- btn_add_n  in  1  active-low add button, raw.
- btn_clr_n  in  1  active-low clear button, raw.
- btn_preset_n  in  1  active-low preset-to-MAX button, raw.
- seg  out  7*DIGITS  active-low segments; digit k (0 = ones) occupies seg[7k+6:7k], bit order gfedcba.
- busy  out  1  conversion in progress or pending.
- overflow  out  1  sticky; set when an add exceeds MAX.

## Operation
- Each button: 2-FF synchroniser, then debouncer. The debounced level changes only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count. A debounced 1->0 transition produces a one-cycle press pulse. Release produces no action.
- Accumulator acc[ACC_W-1:0], updated on the cycle after a press pulse. Priority when pulses coincide: clear > preset > add.
  - clear: acc=0, overflow=0.
  - preset: acc=MAX, overflow=0.
  - add: s = acc + sw computed at ACC_W+1 bits. If s<=MAX, acc=s. Otherwise overflow=1 and acc is set per Configuration.
- Converter FSM states:
  - IDLE: waits for start.
  - SHIFT: ACC_W iterations. Each iteration adds 3 to every nibble >=5, then shifts {bcd,bin} left by 1.
  - LOAD: copies the BCD result to the display register.
  - Transitions: IDLE->SHIFT on start. SHIFT->LOAD after ACC_W cycles. LOAD->IDLE.
- start: pulses on any cycle in which acc is written. If acc is written while the FSM is in SHIFT or LOAD, a pending flag is set. On leaving LOAD with pending set, the FSM returns to SHIFT with a fresh snapshot of acc and clears pending. Snapshots are always taken from acc at SHIFT entry.
- busy = (state != IDLE) | pending.
- Segment decode per digit, 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Any other nibble value gives 1111111 (blank); this is a fully specified default, never a latch.
- rst at any time, including mid-conversion: acc=0, overflow=0, FSM=IDLE, pending=0, debounced levels=1 (released), debounce counters=0, display register=all zeros, so every digit shows 1000000.

## Timing
- Raw press to press pulse: 2 + DEBOUNCE_CYCLES cycles, ±1.
- Press pulse (cycle t) to acc update: edge t+1.
- acc update to new seg value: ACC_W + 2 cycles (1 cycle entering SHIFT, ACC_W shifts, 1 cycle for LOAD). seg is registered and holds its old value until LOAD.
- Back-to-back adds at debounce-limited rate are never lost. Adds arriving mid-conversion coalesce; the final display always equals the final acc.

## Configuration
- BCD_ACC_SAT_EN defined: an overflowing add saturates acc at MAX.
- BCD_ACC_SAT_EN undefined: an overflowing add wraps, acc = s - (MAX+1).
- overflow is set in both cases.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, SW_W=10, DIGITS=6.
- Reset asserted then released -> all six digits 1000000, busy=0, overflow=0.
- sw=1023, three clean add presses -> acc=3069; seg digits 0,0,3,0,6,9 within ACC_W+2 cycles of the last update.
- btn_add_n low pulses of 1-3 cycles separated by highs -> no press pulse; acc unchanged.
- Preset, then add with sw=1 -> with SAT_EN, display 999999 and overflow=1; without it, display 000000 and overflow=1. Then clear -> 000000, overflow=0.
- Clear and add pulses forced in the same cycle -> acc=0. Preset and add in the same cycle -> acc=999999.
- Two adds (sw=5, then sw=7) landing during one conversion -> busy stays high throughout, final display 000012, no intermediate result left showing. Assert rst mid-SHIFT -> display 000000 on release.
